// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared MEM-stage types: cache FSM states, address-field widths, MEM control codes
// Contents:
//   dc_state_t          data cache controller states (IDLE, FILL, WRITE)
//   off_bits/idx_bits/tag_bits  widths of the word-offset, line-index and tag fields of a byte address
//   MEM_LOAD/MEM_STORE  MEM control encoding used by the pipeline
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } dc_state_t;

    localparam logic [1:0] MEM_LOAD  = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b10;

    function automatic int off_bits(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_bits(input int lines);
        return $clog2(lines);
    endfunction

    // Byte address bits [1:0] are dropped, the rest is offset, index, tag.
    function automatic int tag_bits(input int lines, input int words);
        return 30 - $clog2(lines) - $clog2(words);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - data, tag and valid storage for the direct-mapped data cache
// Ports:
//   clk, rst                       clock, synchronous active-high reset (clears every valid bit)
//   rd_index, rd_offset            asynchronous read address
//   rd_data, rd_tag, rd_valid      word, tag and valid bit of the addressed line
//   wr_index, wr_offset, wr_data   single write port; wr_en writes a data word
//   wr_tag, tag_en                 tag_en writes wr_tag and sets the line valid
//   inv_en                         clears the valid bit of wr_index
module dcache_array
    import pipe_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [idx_bits(LINES)-1:0]          rd_index,
    input  logic [off_bits(WORDS)-1:0]          rd_offset,
    output logic [31:0]                         rd_data,
    output logic [tag_bits(LINES, WORDS)-1:0]   rd_tag,
    output logic                                rd_valid,
    input  logic [idx_bits(LINES)-1:0]          wr_index,
    input  logic [off_bits(WORDS)-1:0]          wr_offset,
    input  logic [31:0]                         wr_data,
    input  logic                                wr_en,
    input  logic [tag_bits(LINES, WORDS)-1:0]   wr_tag,
    input  logic                                tag_en,
    input  logic                                inv_en
);

    localparam int TB = tag_bits(LINES, WORDS);

    logic [31:0]      data_mem [0:LINES*WORDS-1];
    logic [TB-1:0]    tag_mem  [0:LINES-1];
    logic [LINES-1:0] valid;

    assign rd_data  = data_mem[{rd_index, rd_offset}];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_valid = valid[rd_index];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[{wr_index, wr_offset}] <= wr_data;
        end
        if (tag_en) begin
            tag_mem[wr_index] <= wr_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (tag_en) begin
            valid[wr_index] <= 1'b1;
        end else if (inv_en) begin
            valid[wr_index] <= 1'b0;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through no-write-allocate data cache controller (MEM stage)
// Ports:
//   clk, rst                                  clock, synchronous active-high reset
//   req_valid, req_we, req_addr, req_wdata    memory-stage request (held stable while busy)
//   rdata                                     load data, valid when req_valid & ~req_we & ~busy
//   busy                                      stall request to pipeline control
//   mem_req, mem_we, mem_addr, mem_wdata      backing-memory request, one outstanding
//   mem_ack, mem_rdata                        backing-memory completion and read data
//   hit_cnt, miss_cnt                         saturating load hit/miss counters (only with DCACHE_STATS_EN)
// Build option: DCACHE_STATS_EN adds the hit/miss counters.
module dcache_ctrl
    import pipe_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int OB = off_bits(WORDS);
    localparam int IB = idx_bits(LINES);
    localparam int TB = tag_bits(LINES, WORDS);
    localparam logic [OB-1:0] LAST = OB'(WORDS - 1);

    dc_state_t     state;
    logic [OB-1:0] cnt;
    logic          done;
    logic [31:0]   done_addr;
    logic [31:0]   done_wdata;

    logic [OB-1:0] offset;
    logic [IB-1:0] index;
    logic [TB-1:0] tag;
    logic [31:0]   arr_data;
    logic [TB-1:0] arr_tag;
    logic          arr_valid;
    logic          hit;
    logic          same_req;
    logic          load_miss;
    logic          store_go;

    assign offset = req_addr[OB+1:2];
    assign index  = req_addr[OB+IB+1:OB+2];
    assign tag    = req_addr[31:OB+IB+2];

    assign hit = arr_valid & (arr_tag == tag);

    // A completed store stays suppressed only while the identical request is held.
    assign same_req  = req_valid & req_we & (req_addr == done_addr) & (req_wdata == done_wdata);
    assign load_miss = req_valid & ~req_we & ~hit;
    assign store_go  = req_valid & req_we & ~(done & same_req);

    assign busy  = (state != IDLE) | load_miss | store_go;
    assign rdata = (state == IDLE && req_valid && !req_we && hit) ? arr_data : 32'h0;

    assign mem_addr  = (state == FILL) ? {tag, index, cnt, 2'b00} : {req_addr[31:2], 2'b00};
    assign mem_wdata = req_wdata;

    // The line is invalidated as the refill starts so an interrupted fill never
    // leaves a mix of old and new words behind a valid tag.
    dcache_array #(
        .LINES(LINES),
        .WORDS(WORDS)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_index (index),
        .rd_offset(offset),
        .rd_data  (arr_data),
        .rd_tag   (arr_tag),
        .rd_valid (arr_valid),
        .wr_index (index),
        .wr_offset((state == FILL) ? cnt : offset),
        .wr_data  ((state == FILL) ? mem_rdata : req_wdata),
        .wr_en    (mem_ack & ((state == FILL) | ((state == WRITE) & hit))),
        .wr_tag   (tag),
        .tag_en   ((state == FILL) & mem_ack & (cnt == LAST)),
        .inv_en   ((state == IDLE) & load_miss)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            done       <= 1'b0;
            done_addr  <= '0;
            done_wdata <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (done && !same_req) begin
                        done <= 1'b0;
                    end
                    if (load_miss) begin
                        state   <= FILL;
                        cnt     <= '0;
                        mem_req <= 1'b1;
                        mem_we  <= 1'b0;
                    end else if (store_go) begin
                        state   <= WRITE;
                        mem_req <= 1'b1;
                        mem_we  <= 1'b1;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        state      <= IDLE;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        done       <= 1'b1;
                        done_addr  <= req_addr;
                        done_wdata <= req_wdata;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // The hit that completes a refilled load belongs to its miss and is not counted again.
    logic refilled;
    logic load_now;

    assign load_now = (state == IDLE) & req_valid & ~req_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            refilled <= 1'b0;
        end else begin
            refilled <= (state == FILL) & mem_ack & (cnt == LAST);
            if (load_now && hit && !refilled && hit_cnt != '1) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
            if (load_now && !hit && miss_cnt != '1) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - self-checking scoreboard bench for dcache_ctrl
module tb_dcache_ctrl;

    localparam int LINES = 16;
    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    always #5 clk = ~clk;

    dcache_ctrl #(
        .LINES(LINES),
        .WORDS(WORDS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rdata    (rdata),
        .busy     (busy),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    int n_cmp = 0;
    int n_bad = 0;
    int beats = 0;
    int lat = 1;
    int run = 0;

    beat_t       exp_q[$];
    logic [31:0] rd_q[$];

    logic [31:0] backing [0:1023];
    logic [31:0] shadow  [0:1023];
    logic        m_valid [0:LINES-1];
    logic [31:0] m_tag   [0:LINES-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Backing memory: responds once the request has been seen for 'lat' cycles;
    // with the request held it keeps acknowledging one beat every 'lat' cycles.
    assign mem_ack   = mem_req && (run >= lat);
    assign mem_rdata = backing[mem_addr[11:2]];

    always @(posedge clk) begin
        run <= mem_req ? (mem_ack ? 1 : run + 1) : 0;
        if (mem_req && mem_we && mem_ack) begin
            backing[mem_addr[11:2]] <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (mem_req && mem_ack) begin
            beat_t b;
            beats++;
            chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                chk("beat_we", 32'(mem_we), 32'(b.we));
                chk("beat_addr", mem_addr, b.addr);
                if (b.we) begin
                    chk("beat_wdata", mem_wdata, b.data);
                end
            end
        end
    end

    task automatic do_op(input logic we, input logic [31:0] addr, input logic [31:0] wd, input int l);
        int    idx;
        int    exp_busy;
        int    cyc;
        logic  hit;
        beat_t b;
        idx = int'(addr[7:4]);
        hit = m_valid[idx] && (m_tag[idx] == {8'h0, addr[31:8]});
        lat = l;
        if (we) begin
            b.we   = 1'b1;
            b.addr = {addr[31:2], 2'b00};
            b.data = wd;
            exp_q.push_back(b);
            shadow[addr[11:2]] = wd;
            exp_busy = 2 + l;
        end else begin
            rd_q.push_back(shadow[addr[11:2]]);
            if (hit) begin
                exp_busy = 0;
            end else begin
                for (int w = 0; w < WORDS; w++) begin
                    b.we   = 1'b0;
                    b.addr = {addr[31:4], 4'h0} + 32'(4 * w);
                    b.data = 32'h0;
                    exp_q.push_back(b);
                end
                exp_busy = 2 + WORDS * l;
                m_valid[idx] = 1'b1;
                m_tag[idx]   = {8'h0, addr[31:8]};
            end
        end
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        #1;
        cyc = 0;
        while (busy && cyc < 500) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        chk(we ? "store_busy_cycles" : "load_busy_cycles", 32'(cyc), 32'(exp_busy));
        if (!we) begin
            chk("rdata", rdata, rd_q.pop_front());
        end else begin
            repeat (2) begin
                @(negedge clk);
                #1;
                chk("store_held_busy", 32'(busy), 32'd0);
            end
        end
        req_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          b0;
        int          cyc;
        logic [31:0] a;
        for (int i = 0; i < 1024; i++) begin
            backing[i] = 32'(i);
            shadow[i]  = 32'(i);
        end
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 32'h0;
        end
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        chk("reset_rdata", rdata, 32'h0);

        do_op(1'b0, 32'h100, 32'h0, 1);
        do_op(1'b0, 32'h104, 32'h0, 1);
        do_op(1'b1, 32'h108, 32'hDEADBEEF, 3);
        do_op(1'b0, 32'h108, 32'h0, 1);
        do_op(1'b1, 32'h500, 32'h12345678, 2);
        do_op(1'b0, 32'h500, 32'h0, 1);
        do_op(1'b0, 32'h100, 32'h0, 1);
        do_op(1'b0, 32'h10C, 32'h0, 2);

        // Reset after the second refill beat of a cold line.
        lat = 3;
        for (int w = 0; w < WORDS; w++) begin
            beat_t b;
            b.we   = 1'b0;
            b.addr = 32'h340 + 32'(4 * w);
            b.data = 32'h0;
            exp_q.push_back(b);
        end
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h344;
        b0  = beats;
        cyc = 0;
        while (beats < b0 + 2 && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("rst_fill_beats", 32'(beats - b0), 32'd2);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
        end
        do_op(1'b0, 32'h344, 32'h0, 1);
        do_op(1'b0, 32'h104, 32'h0, 1);

        for (int k = 0; k < 16; k++) begin
            case ($urandom_range(0, 2))
                0: a = 32'h100;
                1: a = 32'h500;
                default: a = 32'h640;
            endcase
            a = a + 32'(4 * $urandom_range(0, 3));
            do_op(($urandom_range(0, 2) == 0), a, $urandom, int'($urandom_range(1, 3)));
        end

        repeat (4) @(negedge clk);
        chk("beats_left", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
